// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage register with valid/ready.
// Optional 2-entry skid (registered in_ready) via PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
  parameter int unsigned       PC_W      = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              m_valid_q;
  logic              m_valid_d;
  logic [PC_W-1:0]   m_pc_q;
  logic [PC_W-1:0]   m_pc_d;
  logic [DATA_W-1:0] m_data_q;
  logic [DATA_W-1:0] m_data_d;

  logic              acc;
  logic              deq;

  // Present M downstream; invalid slots show a NOP and a zero PC.
  always_comb begin
    out_valid = m_valid_q & ~freeze & ~flush;
    out_pc    = m_valid_q ? m_pc_q : '0;
    out_data  = m_valid_q ? m_data_q : NOP_VALUE;
    deq       = out_valid & out_ready;
  end

`ifdef PIPE_STAGE_SKID_EN

  logic              s_valid_q;
  logic              s_valid_d;
  logic [PC_W-1:0]   s_pc_q;
  logic [PC_W-1:0]   s_pc_d;
  logic [DATA_W-1:0] s_data_q;
  logic [DATA_W-1:0] s_data_d;
  logic [1:0]        count_q;
  logic [1:0]        count_d;

  // Ready comes only from the skid flag, so no ready chain upstream.
  always_comb begin
    in_ready = ~rst & ~s_valid_q & ~freeze & ~flush;
    acc      = in_valid & in_ready;
    count    = count_q;
  end

  // Next state of M and S: flush, then freeze, then transfers.
  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_data_d  = NOP_VALUE;
      s_valid_d = 1'b0;
      s_pc_d    = '0;
      s_data_d  = NOP_VALUE;
    end else if (!freeze) begin
      if (deq) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_pc_d    = s_pc_q;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
          s_pc_d    = '0;
          s_data_d  = NOP_VALUE;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      if (acc) begin
        if (!m_valid_q || deq) begin
          m_valid_d = 1'b1;
          m_pc_d    = in_pc;
          m_data_d  = in_data;
        end else begin
          s_valid_d = 1'b1;
          s_pc_d    = in_pc;
          s_data_d  = in_data;
        end
      end
    end
    count_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
  end

  // State registers; reset drops every held entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_data_q  <= NOP_VALUE;
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_data_q  <= NOP_VALUE;
      count_q   <= 2'd0;
    end else begin
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_data_q  <= s_data_d;
      count_q   <= count_d;
    end
  end

`else

  logic count_q;
  logic count_d;

  // Ready passes through when M is empty or draining this cycle.
  always_comb begin
    in_ready = ~rst & ~freeze & ~flush & (~m_valid_q | out_ready);
    acc      = in_valid & in_ready;
    count    = {1'b0, count_q};
  end

  // Next state of M: flush, then freeze, then transfers.
  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_data_d  = m_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_pc_d    = '0;
      m_data_d  = NOP_VALUE;
    end else if (!freeze) begin
      if (acc) begin
        m_valid_d = 1'b1;
        m_pc_d    = in_pc;
        m_data_d  = in_data;
      end else if (deq) begin
        m_valid_d = 1'b0;
      end
    end
    count_d = m_valid_d;
  end

  // State registers; reset drops the held entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_data_q  <= NOP_VALUE;
      count_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_data_q  <= m_data_d;
      count_q   <= count_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg.
// Expectations follow the build's PIPE_STAGE_SKID_EN setting.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        freeze;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic [1:0]  count;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_in_pc;
  logic [63:0] w_in_data;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_out_pc;
  logic [63:0] w_out_data;
  logic [1:0]  w_count;

  pipe_stage_reg u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .count     (count)
  );

  pipe_stage_reg #(
    .PC_W      (16),
    .DATA_W    (64),
    .NOP_VALUE (64'hDEAD)
  ) u_wide (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .freeze    (1'b0),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_pc     (w_in_pc),
    .in_data   (w_in_data),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_pc    (w_out_pc),
    .out_data  (w_out_data),
    .count     (w_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs vs the model, then advance the model.
  task automatic step();
    logic e_rdy;
    logic e_ov;
    logic acc;
    logic deq;
    ent_t e;
    @(negedge clk);
    if (SKID)
      e_rdy = !flush && !freeze && (sb.size() < 2);
    else
      e_rdy = !flush && !freeze &&
              (sb.size() == 0 || out_ready);
    e_ov = (sb.size() > 0) && !flush && !freeze;
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("count", 64'(count), 64'(sb.size()));
    if (sb.size() > 0) begin
      chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
      chk("out_data", 64'(out_data), 64'(sb[0].data));
    end else begin
      chk("idle_pc", 64'(out_pc), 64'd0);
      chk("idle_data", 64'(out_data), 64'd0);
    end
    acc = in_valid && e_rdy;
    deq = e_ov && out_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
    end else begin
      if (deq) e = sb.pop_front();
      if (acc) sb.push_back('{pc: in_pc, data: in_data});
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] d, input logic r);
    in_valid  = v;
    in_pc     = pc;
    in_data   = d;
    out_ready = r;
  endtask

  localparam logic [31:0] STREAM [3] = '{
    32'hE3A01001, 32'hE2811001, 32'hE1A00000
  };

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    freeze = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    w_in_valid = 1'b0;
    w_in_pc = '0;
    w_in_data = '0;
    w_out_ready = 1'b1;

    // reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // back-to-back stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), STREAM[i], 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) step();

    // backpressure into a full M
    drive(1'b1, 32'h200, 32'h11, 1'b0);
    step();
    drive(1'b1, 32'h204, 32'h22, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) step();
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) step();

    // flush with freeze while full
    drive(1'b1, 32'h300, 32'hAA, 1'b0);
    step();
    drive(1'b1, 32'h304, 32'hBB, 1'b0);
    step();
    drive(1'b1, 32'h308, 32'hCC, 1'b1);
    flush = 1'b1;
    freeze = 1'b1;
    step();
    flush = 1'b0;
    freeze = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    step();
    chk("flush_empty", 64'(count), 64'd0);

    // freeze hold for three cycles
    drive(1'b1, 32'h400, 32'h33, 1'b0);
    step();
    drive(1'b1, 32'h404, 32'h44, 1'b1);
    freeze = 1'b1;
    repeat (3) step();
    freeze = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) step();

    // async reset between edges while stalled
    drive(1'b1, 32'h500, 32'h55, 1'b0);
    step();
    drive(1'b1, 32'h504, 32'h66, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    step();

    // random traffic with occasional flush/freeze
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom(), $urandom(),
            1'($urandom_range(0, 3) != 0));
      flush  = ($urandom_range(0, 15) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      step();
    end
    flush = 1'b0;
    freeze = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) step();

    // wide instance: 16-bit PC, 64-bit payload, NOP 0xDEAD
    @(negedge clk);
    chk("w_idle_data", w_out_data, 64'hDEAD);
    chk("w_idle_valid", 64'(w_out_valid), 64'd0);
    chk("w_in_ready", 64'(w_in_ready), 64'd1);
    @(posedge clk);
    #1;
    w_in_valid = 1'b1;
    w_in_pc = 16'hBEEF;
    w_in_data = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    @(negedge clk);
    chk("w_out_valid", 64'(w_out_valid), 64'd1);
    chk("w_out_pc", 64'(w_out_pc), 64'hBEEF);
    chk("w_out_data", w_out_data, 64'h0123_4567_89AB_CDEF);
    chk("w_count", 64'(w_count), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("w_drain_valid", 64'(w_out_valid), 64'd0);
    chk("w_drain_data", w_out_data, 64'hDEAD);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised inter-stage pipeline register for the ARM pipeline, replacing the fixed 32-bit IF/ID-style registers. It carries a PC word and a payload word between stages with a valid/ready handshake, synchronous flush and freeze. It forces a NOP payload whenever the stage holds no valid entry. An optional 2-entry skid buffer gives a fully registered `in_ready` so ready paths do not chain combinationally across stages.

## Interface
- `PC_W`, 32, width of the PC field
- `DATA_W`, 32, width of the payload field (instruction or control bundle)
- `NOP_VALUE`, 0, payload presented on `out_data` while `out_valid` is 0

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous discard of all held entries
- `freeze`  in  1  synchronous hold of all state; no transfers on either side
- `in_valid`  in  1  upstream entry valid
- `in_ready`  out  1  stage accepts an entry this cycle
- `in_pc`  in  PC_W  upstream PC
- `in_data`  in  DATA_W  upstream payload
- `out_valid`  out  1  downstream entry valid
- `out_ready`  in  1  downstream consumes the entry this cycle
- `out_pc`  out  PC_W  held PC; 0 when `out_valid` is 0
- `out_data`  out  DATA_W  held payload; `NOP_VALUE` when `out_valid` is 0
- `count`  out  2  number of held entries (0..1, or 0..2 with skid)

## Operation
- Storage: main register M (`m_valid`, `m_pc`, `m_data`). With the skid option there is also a skid register S (`s_valid`, `s_pc`, `s_data`).
- Output: `out_valid = m_valid & ~freeze & ~flush`. `out_pc`/`out_data` are M when `m_valid`, else 0/`NOP_VALUE`.
- Accept occurs when `in_valid & in_ready`. Dequeue occurs when `out_valid & out_ready`.
- Priority, highest first:
  - `rst` clears all valids and `count`, and zeroes the PC fields.
  - `flush` clears all valids and zeroes the data registers to `NOP_VALUE`/0. No accept or dequeue happens in a flush cycle, even if `freeze` is also high.
  - `freeze` holds all state unchanged.
  - Normal accept and dequeue.
- Without skid: `in_ready = ~freeze & ~flush & (~m_valid | out_ready)`. On accept, M loads the input. On dequeue with no accept, `m_valid` goes to 0.
- With skid: `in_ready = ~s_valid & ~freeze & ~flush`, where `s_valid` is a register.
  - Accept while M is empty, or while M is dequeued, loads M.
  - Accept while M is full and not dequeued loads S.
  - Dequeue while S is full moves S into M and clears S. There is no accept that cycle, because `in_ready` was 0.
- `count` tracks held entries. It never exceeds its maximum. Accept and dequeue in the same cycle leave it unchanged.

## Timing
- Latency: an entry accepted at edge N is visible on `out_*` after edge N, in the following cycle.
- Throughput: 1 entry/cycle when `out_ready` stays high, in both modes.
- `in_ready`:
  - Without skid: combinational from `out_ready`, `freeze` and `flush`.
  - With skid: depends only on registered state plus `freeze`/`flush`. It deasserts one cycle after the first stalled cycle with M full.
- Reset values: `out_valid=0`, `in_ready=0` while `rst` is high, `out_pc=0`, `out_data=NOP_VALUE`, `count=0`.
- Reset mid-transfer: any held or in-flight entry is lost. There is no partial state.
- Releasing `freeze` resumes exactly the pre-freeze state.

## Configuration
- Macro `PIPE_STAGE_SKID_EN`:
  - Defined: S register is present, `in_ready` is registered as above, and `count` ranges 0..2.
  - Undefined: S is removed, `in_ready` is combinational, `count` ranges 0..1 and its bit 1 is tied 0.

## Test plan
- Reset then stream: `rst` for 2 cycles, then `in_data` = 0xE3A01001, 0xE2811001, 0xE1A00000 with `out_ready=1` → each word appears on `out_data` one cycle after acceptance, back-to-back, with `count=1`.
- Backpressure: M holds 0x11, `out_ready=0`, `in_valid` with 0x22 →
  - Skid mode: 0x22 is stored in S, `count=2`, and `in_ready=0` the next cycle. Releasing `out_ready` outputs 0x11 then 0x22.
  - No-skid mode: `in_ready=0` immediately.
- Flush vs. freeze: `flush=1` and `freeze=1` together with `count=2` → next cycle `out_valid=0`, `out_data=NOP_VALUE`, `out_pc=0`, `count=0`.
- Freeze hold: M=0x33 with `freeze=1` for 3 cycles and `out_ready=1` → `out_valid=0` and `in_ready=0` throughout. After release, `out_data=0x33` is valid again and dequeues normally.
- Async reset mid-stall: `count=2`, assert `rst` between clock edges → outputs reach reset values immediately, without waiting for `clk`.
- Parameter sweep: `PC_W=16`, `DATA_W=64`, `NOP_VALUE=64'hDEAD` → idle `out_data=0xDEAD`, and the full width passes through intact.
